// File: rtl/empacadora.sv
// Sock packer: pairs socks per type, groups pairs into packs and queues
// finished packs in a 4-entry FIFO toward the downstream conveyor.
module empacadora #(
  parameter int PARES_POR_PAQUETE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] TH,
  input  logic       PACK_READY,
  output logic       PACK_VALID,
  output logic [2:0] PACK_TYPE,
  output logic       PAUSA,
  output logic       ERR,
  output logic [7:0] TOTAL
);

  localparam logic [2:0] C_LAST = 3'(PARES_POR_PAQUETE - 1);
  localparam logic [2:0] DEPTH  = 3'd4;

  logic [5:1]      u_q, u_d;
  logic [5:1][2:0] c_q, c_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [2:0]      count_q, count_d;
  logic            pausa_q, pausa_d;
  logic            err_q, err_d;
  logic [7:0]      total_q, total_d;
  logic [2:0]      mem_q [4];
  logic            pair_done;
  logic            push;
  logic            pop;

  assign PACK_VALID = (count_q != 3'd0);
  assign PACK_TYPE  = PACK_VALID ? mem_q[rd_ptr_q] : 3'b000;
  assign PAUSA      = pausa_q;
  assign ERR        = err_q;
  assign TOTAL      = total_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    u_d       = u_q;
    c_d       = c_q;
    err_d     = err_q;
    pair_done = 1'b0;

    if (TH == 3'b110 || TH == 3'b111) begin
      err_d = 1'b1;
    end

    for (int t = 1; t <= 5; t++) begin
      if (TH == 3'(t)) begin
        if (!u_q[t]) begin
          u_d[t] = 1'b1;
        end else begin
          u_d[t] = 1'b0;
          if (c_q[t] == C_LAST) begin
            c_d[t]    = 3'd0;
            pair_done = 1'b1;
          end else begin
            c_d[t] = c_q[t] + 3'd1;
          end
        end
      end
    end

    // A full FIFO still takes a new pack when the head leaves on the same edge.
    pop  = PACK_VALID && PACK_READY;
    push = pair_done && ((count_q != DEPTH) || pop);
    if (pair_done && !push) begin
      err_d = 1'b1;
    end

    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
    total_d  = total_q + {7'd0, pop};
    pausa_d  = (count_d >= 3'd3);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      u_q      <= '0;
      c_q      <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pausa_q  <= 1'b0;
      err_q    <= 1'b0;
      total_q  <= '0;
    end else begin
      u_q      <= u_d;
      c_q      <= c_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pausa_q  <= pausa_d;
      err_q    <= err_d;
      total_q  <= total_d;
    end
  end

  // NOTE: FIFO storage is not reset; PACK_TYPE is masked to 000 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= TH;
    end
  end

endmodule

// File: doc/empacadora.md
EMPACADORA -- requirements
Module: empacadora

Interface
REQ-001 Parameter PARES_POR_PAQUETE, default 3, legal range 2..7: number of sock pairs per pack.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 TH  input  3  sock code from the knitter, sampled every rising edge.
- 000: no sock.
- 001..101: one finished sock of that type.
- 110, 111: invalid.
REQ-005 PACK_READY  input  1  downstream conveyor accepts the pack on PACK_VALID.
REQ-006 PACK_VALID  output  1  a completed pack is presented.
REQ-007 PACK_TYPE  output  3  type of the presented pack (001..101).
REQ-008 PAUSA  output  1  request to upstream knitter to hold production.
REQ-009 ERR  output  1  sticky error flag.
REQ-010 TOTAL  output  8  count of packs delivered.

Function
REQ-011 Per type t (1..5), the block SHALL keep one unmatched-sock bit U[t] and a 3-bit pair counter C[t].
REQ-012 TH=000 SHALL change no state.
REQ-013 TH=t valid with U[t]=0 SHALL set U[t].
REQ-014 TH=t valid with U[t]=1 SHALL clear U[t] and form one pair of type t.
REQ-015 On a pair with C[t] < PARES_POR_PAQUETE-1, the block SHALL increment C[t].
REQ-016 On a pair with C[t] = PARES_POR_PAQUETE-1, the block SHALL clear C[t] and push type t into the pack FIFO in the same edge.
REQ-017 TH in {110,111} SHALL be ignored for U/C/FIFO and SHALL set ERR.
REQ-018 Pack FIFO: depth 4, first-in first-out, holds 3-bit types. PACK_VALID = FIFO not empty; PACK_TYPE = head entry.
REQ-019 Latency: a pack pushed at edge N into an empty FIFO SHALL appear as PACK_VALID=1 with correct PACK_TYPE immediately after edge N.
REQ-020 Transfer occurs at an edge where PACK_VALID=1 and PACK_READY=1; the head is popped and TOTAL increments.
REQ-021 TOTAL SHALL wrap 255 -> 0.
REQ-022 While PACK_VALID=1 and PACK_READY=0, PACK_TYPE SHALL hold stable.
REQ-023 PACK_READY while PACK_VALID=0 SHALL have no effect.
REQ-024 Push and pop in the same edge SHALL both take effect.
- With FIFO full, the push is accepted and occupancy stays 4.
- With FIFO empty, a push and pop cannot coincide; the push is visible next cycle per REQ-019.
REQ-025 Push with FIFO full and no pop SHALL drop the pack and set ERR; C[t] is still cleared.
REQ-026 PAUSA SHALL be 1 exactly when FIFO occupancy >= 3, registered with occupancy.
- Upstream compliance is not enforced; socks arriving during PAUSA are still processed.
REQ-027 ERR SHALL remain 1 until reset.

Reset
REQ-028 reset=1 at a rising edge SHALL clear all of the following, overriding any simultaneous TH or handshake:
- all U[t] and C[t]
- FIFO contents and occupancy
- ERR and TOTAL
REQ-029 Output values after reset: PACK_VALID=0, PACK_TYPE=000, PAUSA=0, ERR=0, TOTAL=0.
REQ-030 Partial pairs and packs in progress at reset SHALL be discarded; no pack SHALL emerge from pre-reset socks.

Verification (PARES_POR_PAQUETE=3)
REQ-031 Six consecutive TH=010, PACK_READY=1 -> PACK_VALID=1, PACK_TYPE=010 right after 6th sock edge; next edge TOTAL=1, PACK_VALID=0.
REQ-032 TH sequence 001,011,001,011 -> no PACK_VALID; C[1]=C[3]=1, U all 0, ERR=0.
REQ-033 PACK_READY=0, five packs completed (types 1,2,3,4,5) -> PAUSA=1 after 3rd push; 5th dropped, ERR=1; then PACK_READY=1 delivers 001,010,011,100 in order, TOTAL=4, PAUSA=0.
REQ-034 FIFO full, pack completion in same edge as a handshake -> no drop, ERR=0, occupancy 4, new type appears last.
REQ-035 TH=111 single cycle -> ERR=1, no U/C/FIFO change; held through later valid traffic until reset.
REQ-036 Five TH=100 then reset, then five TH=100 -> no pack; sixth post-reset TH=100 -> PACK_TYPE=100.
